dr_token_injector: RTL and testbench

Clocked front end for the asynchronous dual-rail ALU pipeline. It debounces the "go" button and latches two 4-bit operands plus the add/subtract select from the switches. It then injects one dual-rail token into the input stages of the ALU using a four-phase return-to-zero handshake, and records completion or timeout. It sits directly upstream of the dual-rail input registers: it replaces direct switch-to-rail wiring and the manual acknowledge button with a controlled, glitch-free token source.

---
 rtl/dr_token_injector.sv | 177 +++++++++++++++++
 tb/tb_dr_token_injector.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_token_injector.sv
// dr_token_injector
//   Clocked front end for the asynchronous dual-rail ALU pipeline. It
//   debounces the go button and latches two 4-bit operands plus add/subtract
//   from the switches. It then injects a single dual-rail token with a
//   four-phase return-to-zero handshake and counts completions. If an
//   acknowledge phase stalls, it flags a timeout.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   drdata[7:0]  operand switches, A = [7:4], B = [3:0]
//   sub          1 = subtract, 0 = add
//   btn_go       raw bouncy push-button (asynchronous)
//   ack_in       acknowledge from the async ALU stage (asynchronous)
//   dr_a[7:0]    dual-rail A, pair i = {true [2i+1], false [2i]}
//   dr_b[7:0]    dual-rail B, same encoding
//   dr_op[1:0]   dual-rail op, [1] = subtract rail, [0] = add rail
//   busy         token in flight (state other than IDLE)
//   err_timeout  sticky timeout flag, cleared by the next accepted go
//   tok_cnt[7:0] completed tokens, wraps 255 -> 0
module dr_token_injector #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] drdata,
    input  logic       sub,
    input  logic       btn_go,
    input  logic       ack_in,
    output logic [7:0] dr_a,
    output logic [7:0] dr_b,
    output logic [1:0] dr_op,
    output logic       busy,
    output logic       err_timeout,
    output logic [7:0] tok_cnt
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, NULL_WAIT, RECOVER} state_t;

    logic [1:0]             btn_sync;
    logic                   btn_lvl;
    logic                   btn_lvl_d;
    logic [DB_W-1:0]        db_cnt;
    logic [SYNC_STAGES-1:0] ack_sr;
    logic                   ack_sync;
    logic                   go;
    state_t                 state;
    logic [TO_W-1:0]        wait_cnt;

    // Dual-rail codeword of a 4-bit value: true rail carries the bit,
    // false rail its complement.
    function automatic logic [7:0] dr_encode(input logic [3:0] v);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    // Button: 2-FF synchronizer, then accept a new level only after it has
    // differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync  <= '0;
            btn_lvl   <= 1'b0;
            btn_lvl_d <= 1'b0;
            db_cnt    <= '0;
        end else begin
            btn_sync  <= {btn_sync[0], btn_go};
            btn_lvl_d <= btn_lvl;
            if (btn_sync[1] != btn_lvl) begin
                if (db_cnt == DB_LAST) begin
                    btn_lvl <= btn_sync[1];
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign go = btn_lvl & ~btn_lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sr <= '0;
        end else begin
            ack_sr <= {ack_sr[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_sync = ack_sr[SYNC_STAGES-1];

    // Handshake FSM. The rail registers double as the operand latch: they
    // are loaded once on the accepted go and only ever return to NULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dr_a        <= '0;
            dr_b        <= '0;
            dr_op       <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            tok_cnt     <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A go while the ALU still acknowledges is dropped so the
                    // handshake never starts from a non-NULL ack phase.
                    if (go && !ack_sync) begin
                        dr_a        <= dr_encode(drdata[7:4]);
                        dr_b        <= dr_encode(drdata[3:0]);
                        dr_op       <= sub ? 2'b10 : 2'b01;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (ack_sync) begin
                        dr_a     <= '0;
                        dr_b     <= '0;
                        dr_op    <= '0;
                        wait_cnt <= '0;
                        state    <= NULL_WAIT;
                    end else if (wait_cnt == TO_LAST) begin
                        dr_a        <= '0;
                        dr_b        <= '0;
                        dr_op       <= '0;
                        err_timeout <= 1'b1;
                        state       <= RECOVER;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                NULL_WAIT: begin
                    if (!ack_sync) begin
                        tok_cnt <= tok_cnt + 8'd1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (wait_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= RECOVER;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    if (!ack_sync) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    dr_a  <= '0;
                    dr_b  <= '0;
                    dr_op <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dr_token_injector.sv
// Testbench for dr_token_injector with short debounce/timeout parameters.
// Stimulus pushes expected tokens (rails at busy rise) and expected
// completions (count/flag at busy fall) into queues; a monitor pops them.
module tb_dr_token_injector;

    localparam int DB  = 4;
    localparam int TO  = 64;
    localparam int SYN = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] drdata = '0;
    logic       sub = 1'b0;
    logic       btn_go = 1'b0;
    logic       ack_in = 1'b0;
    logic [7:0] dr_a;
    logic [7:0] dr_b;
    logic [1:0] dr_op;
    logic       busy;
    logic       err_timeout;
    logic [7:0] tok_cnt;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
    } tok_t;

    typedef struct packed {
        logic [7:0] cnt;
        logic       err;
    } end_t;

    tok_t exp_tok[$];
    end_t exp_end[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] cnt_model = '0;
    logic prev_busy = 1'b0;

    dr_token_injector #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (SYN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .drdata     (drdata),
        .sub        (sub),
        .btn_go     (btn_go),
        .ack_in     (ack_in),
        .dr_a       (dr_a),
        .dr_b       (dr_b),
        .dr_op      (dr_op),
        .busy       (busy),
        .err_timeout(err_timeout),
        .tok_cnt    (tok_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: token presentation on busy rise, completion on busy fall.
    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            if (exp_tok.size() == 0) begin
                chk("unexpected_token", {14'd0, dr_a, dr_b, dr_op}, 32'd0);
            end else begin
                tok_t t;
                t = exp_tok.pop_front();
                chk("token_rails", {14'd0, dr_a, dr_b, dr_op}, {14'd0, t.a, t.b, t.op});
            end
        end
        if (!busy && prev_busy) begin
            if (exp_end.size() == 0) begin
                chk("unexpected_end", {23'd0, tok_cnt, err_timeout}, 32'd0);
            end else begin
                end_t e;
                e = exp_end.pop_front();
                chk("end_cnt_err", {23'd0, tok_cnt, err_timeout}, {23'd0, e.cnt, e.err});
            end
        end
        prev_busy = busy;
    end

    task automatic idle_gap();
        btn_go = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Sets the switches, presses go (left held) and waits for busy.
    task automatic start_token(input logic [7:0] d, input logic s,
                               input logic [7:0] ea, input logic [7:0] eb,
                               input logic [1:0] eop);
        int n;
        drdata = d;
        sub    = s;
        exp_tok.push_back(tok_t'{ea, eb, eop});
        btn_go = 1'b1;
        n = 0;
        while (!busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!busy) chk("go_to_busy_timeout", 32'd0, 32'd1);
        chk("err_clear_on_go", {31'd0, err_timeout}, 32'd0);
    endtask

    // Full acknowledge cycle with edge-exact timing checks.
    task automatic ack_cycle(input logic [7:0] ea, input logic [7:0] eb, input logic [1:0] eop);
        ack_in = 1'b1;
        repeat (SYN) @(negedge clk);
        chk("rails_before_null", {14'd0, dr_a, dr_b, dr_op}, {14'd0, ea, eb, eop});
        @(negedge clk);
        chk("rails_null", {14'd0, dr_a, dr_b, dr_op}, 32'd0);
        chk("busy_null_wait", {31'd0, busy}, 32'd1);
        cnt_model = cnt_model + 8'd1;
        exp_end.push_back(end_t'{cnt_model, 1'b0});
        ack_in = 1'b0;
        repeat (SYN) @(negedge clk);
        chk("busy_before_idle", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("tok_cnt", {24'd0, tok_cnt}, {24'd0, cnt_model});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rails", {14'd0, dr_a, dr_b, dr_op}, 32'd0);
        chk("reset_status", {22'd0, busy, err_timeout, tok_cnt}, 32'd0);
        rst = 1'b0;
        idle_gap();

        // Basic token: A=1010 B=0011 sub
        start_token(8'hA3, 1'b1, 8'h99, 8'h5A, 2'b10);
        chk("busy_on_go", {31'd0, busy}, 32'd1);
        btn_go = 1'b0;
        ack_cycle(8'h99, 8'h5A, 2'b10);
        idle_gap();

        // Bounce 1-0-1 with 2-cycle gaps, then hold ~10 cycles
        btn_go = 1'b1; repeat (2) @(negedge clk);
        btn_go = 1'b0; repeat (2) @(negedge clk);
        start_token(8'h5C, 1'b0, 8'h66, 8'hA5, 2'b01);
        repeat (3) @(negedge clk);
        btn_go = 1'b0;
        ack_cycle(8'h66, 8'hA5, 2'b01);
        idle_gap();

        // Hold 100 cycles: exactly one token
        start_token(8'hF0, 1'b0, 8'hAA, 8'h55, 2'b01);
        ack_cycle(8'hAA, 8'h55, 2'b01);
        repeat (90) @(negedge clk);
        chk("held_no_retrigger", {31'd0, busy}, 32'd0);
        idle_gap();

        // Switch change and second go while in DATA
        start_token(8'hA3, 1'b1, 8'h99, 8'h5A, 2'b10);
        btn_go = 1'b0;
        drdata = 8'hF0;
        sub    = 1'b0;
        repeat (8) @(negedge clk);
        btn_go = 1'b1;
        repeat (10) @(negedge clk);
        btn_go = 1'b0;
        chk("rails_hold_in_data", {14'd0, dr_a, dr_b, dr_op}, {14'd0, 8'h99, 8'h5A, 2'b10});
        ack_cycle(8'h99, 8'h5A, 2'b10);
        repeat (20) @(negedge clk);
        chk("no_queued_go", {31'd0, busy}, 32'd0);

        // Timeout in DATA with ack held low
        start_token(8'h5C, 1'b0, 8'h66, 8'hA5, 2'b01);
        btn_go = 1'b0;
        repeat (TO - 1) @(negedge clk);
        chk("rails_before_timeout", {14'd0, dr_a, dr_b, dr_op}, {14'd0, 8'h66, 8'hA5, 2'b01});
        chk("err_before_timeout", {31'd0, err_timeout}, 32'd0);
        exp_end.push_back(end_t'{cnt_model, 1'b1});
        @(negedge clk);
        chk("rails_timeout_null", {14'd0, dr_a, dr_b, dr_op}, 32'd0);
        chk("err_timeout_set", {31'd0, err_timeout}, 32'd1);
        repeat (2) @(negedge clk);
        chk("tok_cnt_after_timeout", {24'd0, tok_cnt}, {24'd0, cnt_model});
        idle_gap();
        start_token(8'hA3, 1'b1, 8'h99, 8'h5A, 2'b10);
        btn_go = 1'b0;
        ack_cycle(8'h99, 8'h5A, 2'b10);
        idle_gap();

        // ack stuck high in IDLE: go dropped
        ack_in = 1'b1;
        repeat (4) @(negedge clk);
        btn_go = 1'b1;
        repeat (12) @(negedge clk);
        chk("go_dropped_ack_high", {31'd0, busy}, 32'd0);
        btn_go = 1'b0;
        repeat (10) @(negedge clk);
        ack_in = 1'b0;
        repeat (4) @(negedge clk);
        start_token(8'hF0, 1'b0, 8'hAA, 8'h55, 2'b01);
        btn_go = 1'b0;
        ack_cycle(8'hAA, 8'h55, 2'b01);
        idle_gap();

        // Reset during DATA
        start_token(8'hA3, 1'b1, 8'h99, 8'h5A, 2'b10);
        btn_go = 1'b0;
        repeat (3) @(negedge clk);
        cnt_model = '0;
        exp_end.push_back(end_t'{8'd0, 1'b0});
        #2 rst = 1'b1;
        #1;
        chk("rst_rails_null", {14'd0, dr_a, dr_b, dr_op}, 32'd0);
        chk("rst_status", {22'd0, busy, err_timeout, tok_cnt}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        idle_gap();

        // 256 tokens: counter wraps to 0
        for (int k = 0; k < 256; k++) begin
            start_token(8'hA3, 1'b1, 8'h99, 8'h5A, 2'b10);
            btn_go = 1'b0;
            ack_cycle(8'h99, 8'h5A, 2'b10);
            idle_gap();
        end
        chk("tok_cnt_wrap", {24'd0, tok_cnt}, 32'd0);

        repeat (10) @(negedge clk);
        chk("tok_queue_drained", exp_tok.size(), 32'd0);
        chk("end_queue_drained", exp_end.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
